// File: rtl/data_req_responder_pkg.sv
// Shared types for the data-side request responder.
// Entry layout and access-size encoding used by buffer and top.
package data_req_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic        cached;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } data_req_entry_t;

    // Encodings above word are folded onto word.
    function automatic logic [1:0] norm_size(input logic [2:0] sz);
        return (sz > 3'd2) ? SZ_WORD : sz[1:0];
    endfunction

endpackage

// File: rtl/data_req_responder_req_ring_buffer.sv
// Circular store of accepted requests with accept/issue/complete
// pointers and occupancy counters.
module req_ring_buffer
    import data_req_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr_en,
    input  data_req_entry_t            i_wr_entry,
    input  logic                       i_iss_en,
    input  logic                       i_cmp_en,
    output data_req_entry_t            o_iss_entry,
    output logic [$clog2(DEPTH):0]     o_pend,
    output logic [$clog2(DEPTH):0]     o_unissued
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    data_req_entry_t r_mem [DEPTH];
    logic [PW-1:0]   r_acc_ptr;
    logic [PW-1:0]   r_iss_ptr;
    logic [PW-1:0]   r_cmp_ptr;
    logic [CW-1:0]   r_pend;
    logic [CW-1:0]   r_unissued;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_acc_ptr] <= i_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_ptr  <= '0;
            r_iss_ptr  <= '0;
            r_cmp_ptr  <= '0;
            r_pend     <= '0;
            r_unissued <= '0;
        end else begin
            if (i_wr_en) begin
                r_acc_ptr <= r_acc_ptr + PW'(1);
            end
            if (i_iss_en) begin
                r_iss_ptr <= r_iss_ptr + PW'(1);
            end
            if (i_cmp_en) begin
                r_cmp_ptr <= r_cmp_ptr + PW'(1);
            end
            r_pend     <= r_pend + CW'(i_wr_en) - CW'(i_cmp_en);
            r_unissued <= r_unissued + CW'(i_wr_en) - CW'(i_iss_en);
        end
    end

    // Slot at iss_ptr is never the write target while it is unissued.
    assign o_iss_entry = r_mem[r_iss_ptr];
    assign o_pend      = r_pend;
    assign o_unissued  = r_unissued;

endmodule

// File: rtl/data_req_responder.sv
// Responder for the CPU data req/addr_ok/data_ok interface,
// issuing buffered requests in order onto a valid/ready bus.
module data_req_responder
    import data_req_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_iscache,
    input  logic        data_wr,
    input  logic [3:0]  data_offset,
    input  logic [7:0]  data_index,
    input  logic [19:0] data_tag,
    input  logic [2:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wr,
    output logic        mem_cached,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic            w_accept;
    logic            w_valid;
    logic            w_fire;
    logic            w_cmp;
    logic            w_stray;
    logic [CW-1:0]   w_pend;
    logic [CW-1:0]   w_unissued;
    logic [CW-1:0]   w_outst;
    data_req_entry_t w_entry;
    data_req_entry_t w_iss;

    logic            r_data_ok;
    logic [31:0]     r_rdata;
    logic            r_proto_err;

    assign data_addr_ok = (w_pend != FULL);
    assign w_accept     = data_req & data_addr_ok;

    always_comb begin
        w_entry        = '0;
        w_entry.wr     = data_wr;
        w_entry.cached = data_iscache;
        w_entry.addr   = {data_tag, data_index, data_offset};
        w_entry.size   = norm_size(data_size);
        w_entry.wstrb  = data_wr ? data_wstrb : 4'b0000;
        w_entry.wdata  = data_wdata;
    end

    req_ring_buffer #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_accept),
        .i_wr_entry (w_entry),
        .i_iss_en   (w_fire),
        .i_cmp_en   (w_cmp),
        .o_iss_entry(w_iss),
        .o_pend     (w_pend),
        .o_unissued (w_unissued)
    );

    assign w_valid = (w_unissued != '0);
    assign w_fire  = w_valid & mem_req_ready;
    // Only issued-but-unanswered requests may absorb a response.
    assign w_outst = w_pend - w_unissued;
    assign w_cmp   = mem_resp_valid & (w_outst != '0);
    assign w_stray = mem_resp_valid & (w_outst == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_ok   <= 1'b0;
            r_rdata     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_data_ok <= w_cmp;
            if (w_cmp) begin
                r_rdata <= mem_rdata;
            end
            if (w_stray) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign data_data_ok  = r_data_ok;
    assign data_rdata    = r_rdata;
    assign proto_err     = r_proto_err;

    // Buffer slots are not reset, so fields are masked while idle.
    assign mem_req_valid = w_valid;
    assign mem_wr        = w_valid & w_iss.wr;
    assign mem_cached    = w_valid & w_iss.cached;
    assign mem_addr      = w_valid ? w_iss.addr  : '0;
    assign mem_size      = w_valid ? w_iss.size  : '0;
    assign mem_wstrb     = w_valid ? w_iss.wstrb : '0;
    assign mem_wdata     = w_valid ? w_iss.wdata : '0;

endmodule

// File: tb/tb_data_req_responder.sv
// Scoreboard bench for data_req_responder with a small
// in-order downstream memory model.
module tb_data_req_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req, data_iscache, data_wr;
    logic [3:0]  data_offset;
    logic [7:0]  data_index;
    logic [19:0] data_tag;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wr, mem_cached;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        proto_err;

    typedef struct {
        logic        wr;
        logic        cached;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
    } rsp_t;

    req_t        rq[$];
    logic [31:0] cq[$];
    rsp_t        dq[$];

    int n_chk = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_ok  = 0;
    int cyc   = 0;
    int lat   = 2;
    bit auto_rsp = 0;

    data_req_responder #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .data_req(data_req), .data_iscache(data_iscache),
        .data_wr(data_wr), .data_offset(data_offset),
        .data_index(data_index), .data_tag(data_tag),
        .data_size(data_size), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wr(mem_wr), .mem_cached(mem_cached),
        .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h1FC0_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Model: response per issued request, in order, after lat cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_rsp) begin
            mem_resp_valid = 1'b0;
            if (dq.size() != 0 && dq[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = dq[0].rdata;
                void'(dq.pop_front());
            end
        end
    endtask

    task automatic send(input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [3:0] st,
                        input logic [31:0] wd);
        data_req     = 1'b1;
        data_wr      = wr;
        data_iscache = a[4];
        {data_tag, data_index, data_offset} = a;
        data_size    = sz;
        data_wstrb   = st;
        data_wdata   = wd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rq.delete();
        cq.delete();
        dq.delete();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((rq.size() != 0 || cq.size() != 0 || dq.size() != 0)
               && k < budget) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("idle_cq", cq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (data_data_ok) begin
                if (cq.size() == 0) begin
                    chk("spur_ok", data_data_ok, 1'b0);
                end else begin
                    chk("rdata", data_rdata, cq.pop_front());
                    n_ok++;
                end
            end
            if (mem_req_valid) begin
                if (rq.size() == 0) begin
                    chk("spur_req", mem_req_valid, 1'b0);
                end else begin
                    chk("m_addr", mem_addr, rq[0].addr);
                    chk("m_wr", mem_wr, rq[0].wr);
                    chk("m_cached", mem_cached, rq[0].cached);
                    chk("m_size", mem_size, rq[0].size);
                    chk("m_wstrb", mem_wstrb, rq[0].wstrb);
                    if (rq[0].wr) chk("m_wdata", mem_wdata, rq[0].wdata);
                    if (mem_req_ready) begin
                        dq.push_back('{cyc + lat, rd_fn(rq[0].addr)});
                        void'(rq.pop_front());
                    end
                end
            end
            if (data_req && data_addr_ok) begin
                req_t e;
                e.wr     = data_wr;
                e.cached = data_iscache;
                e.addr   = {data_tag, data_index, data_offset};
                e.size   = (data_size > 3'd2) ? 2'd2 : data_size[1:0];
                e.wstrb  = data_wr ? data_wstrb : 4'b0000;
                e.wdata  = data_wdata;
                rq.push_back(e);
                cq.push_back(rd_fn(e.addr));
                n_acc++;
            end
        end
    end

    initial begin
        int n0, n1;
        reset = 1'b1;
        data_req = 0; data_wr = 0; data_iscache = 0;
        data_offset = 0; data_index = 0; data_tag = 0;
        data_size = 0; data_wstrb = 0; data_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        repeat (3) tick();
        chk("rst_aok", data_addr_ok, 1'b1);
        chk("rst_vld", mem_req_valid, 1'b0);
        chk("rst_ok", data_data_ok, 1'b0);
        chk("rst_rdata", data_rdata, 32'h0);
        chk("rst_perr", proto_err, 1'b0);
        chk("rst_maddr", mem_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Single load with a hand-driven response.
        mem_req_ready = 1'b1;
        send(1'b0, 32'h1FC0_0010, 3'd2, 4'hF, 32'h0);
        tick();
        data_req = 1'b0;
        chk("t1_vld", mem_req_valid, 1'b1);
        chk("t1_addr", mem_addr, 32'h1FC0_0010);
        chk("t1_wstrb", mem_wstrb, 4'h0);
        tick();
        chk("t1_vld_lo", mem_req_valid, 1'b0);
        tick();
        dq.delete();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        chk("t1_ok", data_data_ok, 1'b1);
        chk("t1_rdata", data_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t1_ok_lo", data_data_ok, 1'b0);

        // Byte store.
        auto_rsp = 1;
        n0 = n_ok;
        send(1'b1, 32'h0000_1002, 3'd0, 4'b0100, 32'h00AB_0000);
        tick();
        data_req = 1'b0;
        chk("t2_wr", mem_wr, 1'b1);
        chk("t2_size", mem_size, 2'd0);
        chk("t2_wstrb", mem_wstrb, 4'b0100);
        wait_idle(50);
        chk("t2_nok", n_ok - n0, 1);

        // Fill to DEPTH with the bus stalled.
        auto_rsp = 0;
        mem_req_ready = 1'b0;
        n0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 32'h2000 + 32'(4 * (n_acc - n0)), 3'd2, 4'h0, 32'h0);
            tick();
        end
        chk("fill_n", n_acc - n0, 4);
        chk("fill_aok", data_addr_ok, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = dq[0].rdata;
        void'(dq.pop_front());
        chk("full_aok", data_addr_ok, 1'b0);
        n1 = n_acc;
        tick();
        mem_resp_valid = 1'b0;
        chk("full_noacc", n_acc - n1, 0);
        chk("free_aok", data_addr_ok, 1'b1);
        tick();
        data_req = 1'b0;
        chk("fill_n5", n_acc - n0, 5);
        auto_rsp = 1;
        mem_req_ready = 1'b1;
        wait_idle(100);

        // Back-pressure mid-stream, odd size encoding folded to word.
        lat = 1;
        n0 = n_ok;
        send(1'b0, 32'h0, 3'd2, 4'h0, 32'h0);
        tick();
        mem_req_ready = 1'b0;
        send(1'b0, 32'h4, 3'd5, 4'h0, 32'h0);
        tick();
        send(1'b0, 32'h8, 3'd1, 4'h0, 32'h0);
        tick();
        data_req = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        wait_idle(50);
        chk("bp_nok", n_ok - n0, 3);

        // Stray response with nothing issued.
        do_reset();
        auto_rsp = 0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0123;
        tick();
        mem_resp_valid = 1'b0;
        chk("st_perr", proto_err, 1'b1);
        tick();
        chk("st_ok", data_data_ok, 1'b0);
        repeat (3) tick();
        chk("st_sticky", proto_err, 1'b1);

        // Reset with three pending requests.
        do_reset();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'h3000 + 32'(4 * i), 3'd2, 4'h0, 32'h0);
            tick();
        end
        data_req = 1'b0;
        tick();
        chk("pr_vld", mem_req_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("ar_vld", mem_req_valid, 1'b0);
        chk("ar_maddr", mem_addr, 32'h0);
        chk("ar_aok", data_addr_ok, 1'b1);
        chk("ar_ok", data_data_ok, 1'b0);
        chk("ar_rdata", data_rdata, 32'h0);
        chk("ar_perr", proto_err, 1'b0);
        rq.delete();
        cq.delete();
        dq.delete();
        n0 = n_ok;
        tick();
        reset = 1'b0;
        mem_req_ready = 1'b1;
        auto_rsp = 1;
        repeat (5) tick();
        chk("pr_aok", data_addr_ok, 1'b1);
        chk("pr_nok", n_ok - n0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/data_req_responder.md
Name: data_req_responder

Overview:
Responder end of the CPU data-side req/addr_ok/data_ok interface that the pre-memory stage drives. It accepts requests on a one-cycle address handshake and buffers up to DEPTH accepted transactions. It issues them in order as single-beat transactions on a simple valid/ready memory bus, and returns data_ok/rdata to the memory stage in acceptance order. It sits between the CPU core and the uncached bus bridge.

Parameters:
DEPTH, 4, max accepted-but-not-completed transactions (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
data_req  in  1  request valid from pre-MEM
data_iscache  in  1  cacheable attribute, forwarded as mem_cached
data_wr  in  1  1=store, 0=load
data_offset  in  4  addr[3:0]
data_index  in  8  addr[11:4]
data_tag  in  20  addr[31:12] (physical)
data_size  in  3  0=byte, 1=half, 2=word; 3..7 treated as word
data_wstrb  in  4  byte enables for stores
data_wdata  in  32  store data
data_addr_ok  out  1  request accepted this cycle when high with data_req
data_data_ok  out  1  one completion, in order
data_rdata  out  32  load data (raw word, valid with data_data_ok)
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream accepts
mem_wr  out  1  store
mem_cached  out  1  from data_iscache
mem_addr  out  32  {tag,index,offset}
mem_size  out  2  normalised size
mem_wstrb  out  4  byte enables; forced 0 for loads
mem_wdata  out  32  store data
mem_resp_valid  in  1  one response per issued request (loads and stores), in order
mem_rdata  in  32  response data
proto_err  out  1  sticky: response with nothing issued outstanding

Behaviour:
- Storage: circular buffer of DEPTH entries {wr, cached, addr, size, wstrb, wdata}. Three pointers of width clog2(DEPTH): acc_ptr (next write), iss_ptr (next to issue), cmp_ptr (next to complete). Counters: pend (accepted, not completed, 0..DEPTH) and unissued (accepted, not issued).
- data_addr_ok = (pend != DEPTH). Combinational from registered state only, never from data_req. Full with a completion in the same cycle: still not ok (no bypass).
- Accept = data_req & data_addr_ok. Entry written at acc_ptr; acc_ptr++, pend++ on the following edge.
- Issue: mem_req_valid = (unissued != 0). Fields come from entry at iss_ptr, registered-read so there is no combinational path from data_* to mem_*. Minimum latency accept -> mem_req_valid is 1 cycle. Fire = valid & ready; iss_ptr++. mem_req_valid and fields hold stable until fire.
- Completion: mem_resp_valid with (pend - unissued) != 0 gives data_data_ok=1 and data_rdata=mem_rdata on the next cycle, registered, for exactly 1 cycle. cmp_ptr++ and pend--. Store responses also produce data_ok; data_rdata is then don't-care (drive mem_rdata).
- mem_resp_valid with zero issued-outstanding: ignored, proto_err set and held until reset.
- Simultaneous accept + complete: pend unchanged. Simultaneous accept + issue: unissued unchanged. All pointers wrap modulo DEPTH.
- Size normalisation: mem_size = (data_size>2) ? 2 : data_size[1:0].
- Accepted requests are never cancelled; pipeline flushes do not reach this block.
- Reset (async assert, sync deassert expected upstream): pointers/counters=0, data_addr_ok=1 after reset, mem_req_valid=0, data_data_ok=0, data_rdata=0, proto_err=0, other mem_* outputs=0. In-flight downstream transactions are dropped; the downstream must be reset together.

Decomposition:
- Shared cpu package: data_req_entry_t struct (wr, cached, addr, size, wstrb, wdata); size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module: req_ring_buffer (DEPTH-parameterised storage + pointers, write/issue/complete strobes, count outputs).

Test Plan:
- Single load addr 0x1FC0_0010 size 2, mem_req_ready=1, response 0xDEADBEEF 2 cycles later: mem_req_valid 1 cycle after accept, mem_addr=0x1FC00010, wstrb=0; data_data_ok 1 cycle after resp with rdata=0xDEADBEEF.
- Store byte wstrb=4'b0100 wdata=0x00AB0000: mem_wr=1, mem_size=0, mem_wstrb=4'b0100; data_data_ok pulses once on write response.
- Fill: data_req held high, mem_req_ready=0: exactly 4 accepts, then addr_ok=0. With one response the same cycle as a 5th req, no accept that cycle; next cycle addr_ok=1.
- Back-pressure: ready low 3 cycles mid-stream: mem_* fields stable; order preserved (addresses 0x0,0x4,0x8 complete in that order).
- Stray mem_resp_valid after reset with nothing issued: no data_ok, proto_err=1 and sticky.
- Reset asserted with 3 pending: all outputs at reset values immediately; after release addr_ok=1, no spurious data_ok.
